// File: rtl/led_ctrl_pkg.sv
// Shared encodings between the button control stage and the LED blink stage.
// The blink stage decodes mode_t directly; keep encodings stable.
package led_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_10HZ = 2'd0;
  localparam mode_t MODE_5HZ  = 2'd1;
  localparam mode_t MODE_2HZ  = 2'd2;
  localparam mode_t MODE_1HZ  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  // Rate steps 10 -> 5 -> 2 -> 1 -> 10 Hz; the 2-bit add wraps 3 -> 0.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    n = m + 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Button debounce: 2-FF synchroniser, output follows input after g_DEBOUNCE_LIMIT stable cycles.
// Latency 2+g_DEBOUNCE_LIMIT cycles from raw edge; no backpressure (free-running level filter).
module debounce_filter #(
  parameter int g_DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch
);

  localparam int CW = (g_DEBOUNCE_LIMIT > 1) ? $clog2(g_DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(g_DEBOUNCE_LIMIT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = i_Switch;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    // Any cycle where the synced level agrees with the output restarts the count.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Switch = deb_q;

endmodule

// File: rtl/button_mode_select.sv
// Classifies debounced presses: short steps the blink rate, long toggles LED enable.
// o_Update lags the deciding edge/threshold by 1 cycle; no backpressure, all outputs registered.
module button_mode_select
  import led_ctrl_pkg::*;
#(
  parameter int g_DEBOUNCE_LIMIT = 250000,
  parameter int g_LONG_PRESS     = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic [1:0] o_Mode,
  output logic       o_LED_En,
  output logic       o_Update,
  output logic       o_Debounced
);

  localparam int HW = (g_LONG_PRESS > 1) ? $clog2(g_LONG_PRESS) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(g_LONG_PRESS - 1);

  logic          deb;
  logic          deb_q, deb_d;
  logic          rise, fall;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  mode_t         mode_q, mode_d;
  logic          led_en_q, led_en_d;
  logic          update_q, update_d;

  debounce_filter #(
    .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)
  ) u_debounce (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Switch(i_Switch),
    .o_Switch(deb)
  );

  assign rise = deb & ~deb_q;
  assign fall = ~deb & deb_q;

  always_comb begin
    deb_d    = deb;
    state_d  = state_q;
    hold_d   = hold_q;
    mode_d   = mode_q;
    led_en_d = led_en_q;
    update_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // Release is checked first so a release on the threshold cycle is a short press.
        if (fall) begin
          mode_d   = next_mode(mode_q);
          update_d = 1'b1;
          state_d  = IDLE;
        end else if (hold_q == HOLD_MAX) begin
          led_en_d = ~led_en_q;
          update_d = 1'b1;
          state_d  = LONG_HELD;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      deb_q    <= 1'b0;
      state_q  <= IDLE;
      hold_q   <= '0;
      mode_q   <= MODE_10HZ;
      led_en_q <= 1'b1;
      update_q <= 1'b0;
    end else begin
      deb_q    <= deb_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      mode_q   <= mode_d;
      led_en_q <= led_en_d;
      update_q <= update_d;
    end
  end

  assign o_Mode      = mode_q;
  assign o_LED_En    = led_en_q;
  assign o_Update    = update_q;
  assign o_Debounced = deb;

endmodule

// File: tb/tb_button_mode_select.sv
// Bench for button_mode_select with short debounce/long-press parameters.
module tb_button_mode_select;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic [1:0] o_Mode;
  logic       o_LED_En;
  logic       o_Update;
  logic       o_Debounced;

  int checks   = 0;
  int failures = 0;

  // Reference state: press classified by how many cycles the debounced level stayed high.
  logic [1:0] m_mode = 2'd0;
  logic       m_en   = 1'b1;
  logic       m_upd  = 1'b0;
  logic       m_deb  = 1'b0;
  int         m_run  = 0;
  int         m_high = 0;
  logic       sw_q[$] = '{1'b0, 1'b0};

  button_mode_select #(
    .g_DEBOUNCE_LIMIT(DEB),
    .g_LONG_PRESS    (LONG)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Switch   (sw),
    .o_Mode     (o_Mode),
    .o_LED_En   (o_LED_En),
    .o_Update   (o_Update),
    .o_Debounced(o_Debounced)
  );

  always #1 clk = ~clk;

  task automatic model_edge(input logic s, input logic r);
    logic synced;
    if (r) begin
      m_mode = 2'd0; m_en = 1'b1; m_upd = 1'b0; m_deb = 1'b0;
      m_run = 0; m_high = 0;
      sw_q = '{1'b0, 1'b0};
    end else begin
      m_upd = 1'b0;
      if (m_deb) begin
        m_high++;
        if (m_high == LONG + 1) begin
          m_en  = ~m_en;
          m_upd = 1'b1;
        end
      end else begin
        if (m_high > 0 && m_high <= LONG) begin
          m_mode = m_mode + 2'd1;
          m_upd  = 1'b1;
        end
        m_high = 0;
      end
      synced = sw_q[0];
      void'(sw_q.pop_front());
      sw_q.push_back(s);
      if (synced != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = synced;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic tick(input logic s, input logic r);
    sw  = s;
    rst = r;
    @(posedge clk);
    model_edge(s, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== 5'b00100) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got=%b exp=00100", i, {o_Mode, o_LED_En, o_Update, o_Debounced});
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 13; i++) begin
      tick(i < 3, 1'b0);
      checks++;
      if (o_Debounced !== 1'b0 || o_Update !== 1'b0) begin
        failures++;
        $display("FAIL glitch cyc=%0d got deb=%b upd=%b exp deb=0 upd=0", i, o_Debounced, o_Update);
      end
      checks++;
      if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== {m_mode, m_en, m_upd, m_deb}) begin
        failures++;
        $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i, {o_Mode, o_LED_En, o_Update, o_Debounced}, {m_mode, m_en, m_upd, m_deb});
      end
    end
  endtask

  task automatic test_short_press();
    int lat = -1;
    int pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick(i < 10, 1'b0);
      if (lat < 0 && o_Debounced === 1'b1) lat = i + 1;
      if (o_Update === 1'b1) pulses++;
      checks++;
      if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== {m_mode, m_en, m_upd, m_deb}) begin
        failures++;
        $display("FAIL short_model cyc=%0d got=%b exp=%b", i, {o_Mode, o_LED_En, o_Update, o_Debounced}, {m_mode, m_en, m_upd, m_deb});
      end
    end
    checks++;
    if (lat != 6) begin
      failures++;
      $display("FAIL short_deb_latency got=%0d exp=6", lat);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL short_update_count got=%0d exp=1", pulses);
    end
    checks++;
    if (o_Mode !== 2'd1) begin
      failures++;
      $display("FAIL short_mode got=%0d exp=1", o_Mode);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    logic [1:0] exp_seq[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    tick(1'b0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 24; i++) begin
        tick(i < 10, 1'b0);
        if (o_Update === 1'b1) pulses++;
        checks++;
        if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== {m_mode, m_en, m_upd, m_deb}) begin
          failures++;
          $display("FAIL wrap_model p=%0d cyc=%0d got=%b exp=%b", p, i, {o_Mode, o_LED_En, o_Update, o_Debounced}, {m_mode, m_en, m_upd, m_deb});
        end
      end
      checks++;
      if (o_Mode !== exp_seq[p]) begin
        failures++;
        $display("FAIL wrap_mode p=%0d got=%0d exp=%0d", p, o_Mode, exp_seq[p]);
      end
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL wrap_update_count got=%0d exp=4", pulses);
    end
  endtask

  task automatic test_long_press();
    logic [1:0] exp_mode;
    for (int r = 0; r < 2; r++) begin
      int pulses = 0;
      int at = -1;
      exp_mode = m_mode;
      for (int i = 0; i < 54; i++) begin
        tick(i < 40, 1'b0);
        if (o_Update === 1'b1) begin
          pulses++;
          if (at < 0) at = i + 1;
        end
        checks++;
        if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== {m_mode, m_en, m_upd, m_deb}) begin
          failures++;
          $display("FAIL long_model r=%0d cyc=%0d got=%b exp=%b", r, i, {o_Mode, o_LED_En, o_Update, o_Debounced}, {m_mode, m_en, m_upd, m_deb});
        end
      end
      checks++;
      if (pulses != 1 || at != 27) begin
        failures++;
        $display("FAIL long_update r=%0d got pulses=%0d at=%0d exp pulses=1 at=27", r, pulses, at);
      end
      checks++;
      if (o_LED_En !== (r == 1) || o_Mode !== exp_mode) begin
        failures++;
        $display("FAIL long_state r=%0d got en=%b mode=%0d exp en=%b mode=%0d", r, o_LED_En, o_Mode, (r == 1), exp_mode);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    for (int i = 0; i < 17; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    checks++;
    if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== 5'b00100) begin
      failures++;
      $display("FAIL midreset_values got=%b exp=00100", {o_Mode, o_LED_En, o_Update, o_Debounced});
    end
    for (int i = 0; i < 54; i++) begin
      tick(i < 40, 1'b0);
      if (o_Update === 1'b1) pulses++;
      checks++;
      if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== {m_mode, m_en, m_upd, m_deb}) begin
        failures++;
        $display("FAIL midreset_model cyc=%0d got=%b exp=%b", i, {o_Mode, o_LED_En, o_Update, o_Debounced}, {m_mode, m_en, m_upd, m_deb});
      end
    end
    checks++;
    if (pulses != 1 || o_LED_En !== 1'b0 || o_Mode !== 2'd0) begin
      failures++;
      $display("FAIL midreset_after got pulses=%0d en=%b mode=%0d exp pulses=1 en=0 mode=0", pulses, o_LED_En, o_Mode);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 160; seg++) begin
      logic lvl;
      int len;
      logic do_rst;
      lvl    = 1'($urandom_range(0, 1));
      len    = int'($urandom_range(1, 30));
      do_rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < len; i++) begin
        tick(lvl, do_rst && i == 0);
        checks++;
        if ({o_Mode, o_LED_En, o_Update, o_Debounced} !== {m_mode, m_en, m_upd, m_deb}) begin
          failures++;
          $display("FAIL random_model seg=%0d cyc=%0d got=%b exp=%b", seg, i, {o_Mode, o_LED_En, o_Update, o_Debounced}, {m_mode, m_en, m_upd, m_deb});
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_short_press();
    test_wrap();
    test_long_press();
    test_reset_mid_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
